hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised register scoreboard for the MIPS32 pipeline. It supersedes pure stage-compare hazard logic so that variable-latency producers (loads, multi-cycle ALU/MDU ops, coprocessor reads) can be tracked without hard-wiring pipeline depth. It sits beside the ID stage and records, per architectural register, whether a write is outstanding, which tag owns it, and how many cycles remain until the result reaches a bypass point. From that state it generates ID stall and per-source forward-ready signals.

## Interface
Parameters:
- NREG, 32: architectural registers; register 0 is never tracked.
- NSRC, 2: source-operand ports checked per cycle.
- LAT_W, 3: latency counter width; maximum issue latency is 2^LAT_W-1.
- TAG_W, 4: producer tag width, used to match writeback clears.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_issue  in  1  ID instruction wants to advance this cycle.
- id_wr_en  in  1  issuing instruction writes a register.
- id_wr_reg  in  log2(NREG)  destination register.
- id_wr_tag  in  TAG_W  producer tag of the issuing instruction.
- id_wr_lat  in  LAT_W  cycles from issue until the result is forwardable; 0 means forwardable from the next cycle.
- id_src_reg  in  NSRC*log2(NREG)  source registers, port k at bits [k*log2(NREG) +: log2(NREG)].
- id_src_need  in  NSRC  source k is needed in ID (stall if not ready).
- pipe_hold  in  1  downstream stall; freezes counters and blocks issue.
- wb_wr_en  in  1  a producer completes its register write this cycle.
- wb_wr_reg  in  log2(NREG)  register written back.
- wb_wr_tag  in  TAG_W  tag of the completing producer.
- id_stall  out  1  ID must hold this cycle.
- src_fwd_ready  out  NSRC  source k is pending but its value is on a bypass path.
- pending  out  NREG  registered pending vector.
- busy_cnt  out  log2(NREG)+1  number of pending entries.

## Operation
- Each entry holds a pending bit, a tag (TAG_W) and a count (LAT_W). Entry 0 is constant zero.
- issue_fire = id_issue & ~id_stall & ~pipe_hold.
- Issue: on issue_fire & id_wr_en & (id_wr_reg != 0), the entry loads pending=1, tag=id_wr_tag, count=id_wr_lat.
- Countdown: when ~pipe_hold, every pending entry with count>0 decrements by 1 and saturates at 0. When pipe_hold=1, all counts hold.
- Clear: wb_wr_en with a pending entry at wb_wr_reg whose tag equals wb_wr_tag clears that entry's pending bit. A tag mismatch is ignored, because a younger producer owns the entry.
- Same-cycle issue and clear on the same register: issue wins. The entry ends pending with the new tag and count.
- Source k is blocked if pending[src]=1, count>0, id_src_need[k]=1, and it is not being cleared this cycle by a tag-matched wb.
- Forward ready: src_fwd_ready[k]=1 if pending[src] & count==0, or if a tag-matched wb is in progress on src. Always 0 for src 0.
- WAW hazard: id_wr_en with pending[id_wr_reg]=1 and id_wr_lat < count stalls ID, so a younger result cannot retire before an older one.
- id_stall = OR over k of blocked[k] | WAW. id_stall does not include pipe_hold.
- busy_cnt is the popcount of the registered pending vector.

## Timing
- Reset (asynchronous, reset_n=0): all pending, tag and count bits are 0, so pending=0 and busy_cnt=0. id_stall and src_fwd_ready evaluate to 0 unless driven by inputs in the same cycle. Reset asserted mid-operation discards all outstanding entries immediately.
- id_stall and src_fwd_ready are combinational from registered state plus same-cycle wb and id inputs. There are no state-to-output registers.
- State changes are visible on the cycle after issue or clear. An entry issued at cycle t with lat=L and no hold has count 0 at cycle t+1+L.
- busy_cnt saturation cannot occur, since its width covers NREG.
- Writing register 0 never changes state, and reading register 0 never stalls.

## Test plan
- Reset: with reset_n low, drive random inputs; then pending=0, busy_cnt=0 and id_stall=0 whenever id_src_need=0.
- Load-use: issue r5 with lat=1 and tag=3, then request src0=r5 with need=1. Required: id_stall=1 at t+1, then at t+2 id_stall=0 and src_fwd_ready[0]=1. A wb of r5 with tag 3 then drops pending[5].
- Hold freeze: issue r7 with lat=2, then hold pipe_hold=1 for 3 cycles. Required: id_stall stays 1 for src r7 throughout the hold, then releases 2 cycles after hold deasserts.
- Tag mismatch: r9 is pending with tag 2 and a wb for r9 arrives with tag 1. Required: pending[9] stays 1. A wb with tag 2 then clears it.
- Simultaneous: in one cycle, issue r4 with tag 6 and lat 3 while a wb of r4 with the old tag 5 occurs. Required: pending[4]=1 with tag 6, and busy_cnt is unchanged.
- WAW and r0: with r3 pending count 4, issue r3 with lat=1. Required: id_stall=1 until count ≤ 1. Separately, issue r0 and check that busy_cnt is unchanged and src r0 never stalls.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register scoreboard beside ID: tracks outstanding writes per register,
// owning tag and cycles to forwardable, and derives ID stall / fwd-ready.

// Per-source hazard check: one instance per source-operand port.
module hazard_src_chk #(
  parameter int LAT_W = 3
) (
  input  logic             src_zero,
  input  logic             src_pend,
  input  logic [LAT_W-1:0] src_cnt,
  input  logic             src_need,
  input  logic             wb_hit,
  output logic             blocked,
  output logic             fwd_ready
);
  logic cnt_zero;
  // Pending with count left stalls unless the owning producer retires now.
  always_comb begin
    cnt_zero  = (src_cnt == '0);
    blocked   = !src_zero && src_pend && !cnt_zero && src_need && !wb_hit;
    fwd_ready = !src_zero && ((src_pend && cnt_zero) || wb_hit);
  end
endmodule

module hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int NSRC  = 2,
  parameter int LAT_W = 3,
  parameter int TAG_W = 4,
  localparam int RW   = $clog2(NREG)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               id_issue,
  input  logic               id_wr_en,
  input  logic [RW-1:0]      id_wr_reg,
  input  logic [TAG_W-1:0]   id_wr_tag,
  input  logic [LAT_W-1:0]   id_wr_lat,
  input  logic [NSRC*RW-1:0] id_src_reg,
  input  logic [NSRC-1:0]    id_src_need,
  input  logic               pipe_hold,
  input  logic               wb_wr_en,
  input  logic [RW-1:0]      wb_wr_reg,
  input  logic [TAG_W-1:0]   wb_wr_tag,
  output logic               id_stall,
  output logic [NSRC-1:0]    src_fwd_ready,
  output logic [NREG-1:0]    pending,
  output logic [RW:0]        busy_cnt
);
  typedef struct packed {
    logic             pend;
    logic [TAG_W-1:0] tag;
    logic [LAT_W-1:0] cnt;
  } entry_t;

  entry_t [NREG-1:0] ent_q;
  logic              wb_clr;
  logic              waw;
  logic              issue_fire;
  logic [NSRC-1:0]   blocked;
  entry_t            wr_ent;

  // Writeback clears only when the completing tag still owns the entry.
  always_comb begin
    wb_clr = wb_wr_en && (wb_wr_reg != '0) && ent_q[wb_wr_reg].pend &&
             (ent_q[wb_wr_reg].tag == wb_wr_tag);
    wr_ent = ent_q[id_wr_reg];
    // A younger write must not become forwardable before the older one.
    waw    = id_wr_en && (id_wr_reg != '0) && wr_ent.pend &&
             (id_wr_lat < wr_ent.cnt);
    id_stall   = (|blocked) || waw;
    issue_fire = id_issue && !id_stall && !pipe_hold;
  end

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    logic [RW-1:0] sreg;
    assign sreg = id_src_reg[k*RW +: RW];
    hazard_src_chk #(.LAT_W(LAT_W)) u_chk (
      .src_zero  (sreg == '0),
      .src_pend  (ent_q[sreg].pend),
      .src_cnt   (ent_q[sreg].cnt),
      .src_need  (id_src_need[k]),
      .wb_hit    (wb_clr && (wb_wr_reg == sreg)),
      .blocked   (blocked[k]),
      .fwd_ready (src_fwd_ready[k])
    );
  end

  // Entry update: issue beats same-cycle clear; counts freeze under hold.
  // Entry 0 is never written after reset and stays zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent_q <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (issue_fire && id_wr_en && (id_wr_reg == RW'(i))) begin
          ent_q[i].pend <= 1'b1;
          ent_q[i].tag  <= id_wr_tag;
          ent_q[i].cnt  <= id_wr_lat;
        end else begin
          if (wb_clr && (wb_wr_reg == RW'(i))) ent_q[i].pend <= 1'b0;
          if (!pipe_hold && ent_q[i].pend && (ent_q[i].cnt != '0))
            ent_q[i].cnt <= ent_q[i].cnt - LAT_W'(1);
        end
      end
    end
  end

  // Pending vector and its popcount straight from registered state.
  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      pending[i] = ent_q[i].pend;
      busy_cnt   = busy_cnt + (RW+1)'(ent_q[i].pend);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with an expectation queue.
module tb_hazard_scoreboard;
  localparam int NREG = 32, NSRC = 2, LAT_W = 3, TAG_W = 4, RW = 5;

  logic               clock = 0;
  logic               reset_n;
  logic               id_issue, id_wr_en, pipe_hold, wb_wr_en;
  logic [RW-1:0]      id_wr_reg, wb_wr_reg;
  logic [TAG_W-1:0]   id_wr_tag, wb_wr_tag;
  logic [LAT_W-1:0]   id_wr_lat;
  logic [NSRC*RW-1:0] id_src_reg;
  logic [NSRC-1:0]    id_src_need;
  logic               id_stall;
  logic [NSRC-1:0]    src_fwd_ready;
  logic [NREG-1:0]    pending;
  logic [RW:0]        busy_cnt;

  hazard_scoreboard #(.NREG(NREG), .NSRC(NSRC), .LAT_W(LAT_W), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n), .id_issue(id_issue), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_wr_tag(id_wr_tag), .id_wr_lat(id_wr_lat),
    .id_src_reg(id_src_reg), .id_src_need(id_src_need), .pipe_hold(pipe_hold),
    .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg), .wb_wr_tag(wb_wr_tag),
    .id_stall(id_stall), .src_fwd_ready(src_fwd_ready), .pending(pending),
    .busy_cnt(busy_cnt));

  always #5 clock = ~clock;

  typedef enum int {K_STALL, K_FWD, K_PEND, K_BUSY, K_PVEC} kind_t;
  typedef struct {
    string       nm;
    kind_t       kind;
    int          idx;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [63:0] observe(kind_t k, int idx);
    case (k)
      K_STALL: return 64'(id_stall);
      K_FWD:   return 64'(src_fwd_ready[idx]);
      K_PEND:  return 64'(pending[idx]);
      K_BUSY:  return 64'(busy_cnt);
      default: return 64'(pending);
    endcase
  endfunction

  task automatic expect_val(string nm, kind_t k, int idx, logic [63:0] v);
    exp_t e;
    e.nm = nm; e.kind = k; e.idx = idx; e.exp = v;
    q.push_back(e);
  endtask

  // Pop every queued expectation and compare against the settled outputs.
  task automatic drain();
    exp_t e;
    logic [63:0] o;
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = observe(e.kind, e.idx);
      n_assert++;
      assert (o === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.nm, o, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic idle();
    id_issue = 0; id_wr_en = 0; id_wr_reg = 0; id_wr_tag = 0; id_wr_lat = 0;
    id_src_reg = 0; id_src_need = 0; pipe_hold = 0;
    wb_wr_en = 0; wb_wr_reg = 0; wb_wr_tag = 0;
  endtask

  task automatic issue(int r, int tag, int lat);
    id_issue = 1; id_wr_en = 1; id_wr_reg = RW'(r);
    id_wr_tag = TAG_W'(tag); id_wr_lat = LAT_W'(lat);
  endtask

  task automatic wb(int r, int tag);
    wb_wr_en = 1; wb_wr_reg = RW'(r); wb_wr_tag = TAG_W'(tag);
  endtask

  task automatic src(int k, int r, bit need);
    id_src_reg[k*RW +: RW] = RW'(r);
    id_src_need[k] = need;
  endtask

  initial begin
    idle();
    reset_n = 0;
    // Reset with random activity: no state may be captured.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      id_issue = 1'($urandom); id_wr_en = 1'($urandom); id_wr_reg = RW'($urandom);
      id_wr_tag = TAG_W'($urandom); id_wr_lat = LAT_W'($urandom);
      id_src_reg = (NSRC*RW)'($urandom); id_src_need = 0;
      wb_wr_en = 1'($urandom); wb_wr_reg = RW'($urandom); wb_wr_tag = TAG_W'($urandom);
    end
    expect_val("rst_pvec", K_PVEC, 0, 0);
    expect_val("rst_busy", K_BUSY, 0, 0);
    expect_val("rst_stall", K_STALL, 0, 0);
    drain();
    step(); idle(); reset_n = 1; step();

    // Load-use on r5, lat 1, tag 3.
    issue(5, 3, 1);
    drain();
    step(); idle(); src(0, 5, 1);
    expect_val("lu_stall_t1", K_STALL, 0, 1);
    expect_val("lu_fwd_t1", K_FWD, 0, 0);
    expect_val("lu_busy", K_BUSY, 0, 1);
    drain();
    step();
    expect_val("lu_stall_t2", K_STALL, 0, 0);
    expect_val("lu_fwd_t2", K_FWD, 0, 1);
    drain();
    idle(); wb(5, 3);
    step(); idle();
    expect_val("lu_clr_pend5", K_PEND, 5, 0);
    expect_val("lu_clr_busy", K_BUSY, 0, 0);
    drain();

    // Hold freezes r7 countdown.
    issue(7, 1, 2);
    step(); idle(); src(0, 7, 1); pipe_hold = 1;
    expect_val("hold_stall_0", K_STALL, 0, 1);
    drain();
    for (int i = 0; i < 3; i++) begin
      step();
      expect_val("hold_stall_in", K_STALL, 0, 1);
      drain();
    end
    pipe_hold = 0;
    expect_val("hold_rel_0", K_STALL, 0, 1);
    drain();
    step();
    expect_val("hold_rel_1", K_STALL, 0, 1);
    drain();
    step();
    expect_val("hold_rel_2", K_STALL, 0, 0);
    expect_val("hold_fwd", K_FWD, 0, 1);
    drain();
    idle(); wb(7, 1); step(); idle();

    // Tag mismatch on r9 is ignored.
    issue(9, 2, 0);
    step(); idle(); wb(9, 1);
    step(); idle();
    expect_val("tm_keep_pend9", K_PEND, 9, 1);
    drain();
    wb(9, 2);
    step(); idle();
    expect_val("tm_clr_pend9", K_PEND, 9, 0);
    drain();

    // Simultaneous issue (tag 6) and old-tag wb (tag 5) on r4.
    issue(4, 5, 0);
    step(); idle();
    expect_val("sim_busy_pre", K_BUSY, 0, 1);
    drain();
    issue(4, 6, 3); wb(4, 5);
    step(); idle();
    expect_val("sim_pend4", K_PEND, 4, 1);
    expect_val("sim_busy", K_BUSY, 0, 1);
    drain();
    src(1, 4, 1); wb(4, 5);
    expect_val("sim_oldtag_stall", K_STALL, 0, 1);
    drain();
    step(); idle();
    expect_val("sim_oldtag_pend4", K_PEND, 4, 1);
    drain();
    src(1, 4, 1); wb(4, 6);
    expect_val("sim_newtag_stall", K_STALL, 0, 0);
    expect_val("sim_newtag_fwd", K_FWD, 1, 1);
    drain();
    step(); idle();
    expect_val("sim_clr_busy", K_BUSY, 0, 0);
    drain();

    // WAW: r3 count 4, younger lat-1 write waits until count <= 1.
    issue(3, 7, 4);
    step(); idle(); issue(3, 8, 1);
    expect_val("waw_c4", K_STALL, 0, 1);
    drain();
    step();
    expect_val("waw_c3", K_STALL, 0, 1);
    drain();
    step();
    expect_val("waw_c2", K_STALL, 0, 1);
    drain();
    step();
    expect_val("waw_c1", K_STALL, 0, 0);
    drain();
    step(); idle();
    expect_val("waw_pend3", K_PEND, 3, 1);
    expect_val("waw_busy", K_BUSY, 0, 1);
    drain();
    wb(3, 7); step(); idle();
    expect_val("waw_oldtag_keep", K_PEND, 3, 1);
    drain();
    wb(3, 8); step(); idle();
    expect_val("waw_newtag_clr", K_BUSY, 0, 0);
    drain();

    // r0 writes are dropped and r0 reads never stall.
    issue(0, 9, 5); src(0, 0, 1); src(1, 0, 1);
    expect_val("r0_stall", K_STALL, 0, 0);
    expect_val("r0_fwd", K_FWD, 0, 0);
    drain();
    step(); idle();
    expect_val("r0_busy", K_BUSY, 0, 0);
    expect_val("r0_pend0", K_PEND, 0, 0);
    drain();

    // Asynchronous reset mid-operation discards entries at once.
    issue(10, 1, 3);
    step(); idle();
    expect_val("mid_busy", K_BUSY, 0, 1);
    drain();
    #1 reset_n = 0;
    expect_val("mid_rst_pvec", K_PVEC, 0, 0);
    expect_val("mid_rst_busy", K_BUSY, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
